// File: rtl/fsm_event_monitor.sv
// Measures high runs on the detector pulse, filters short glitches and reports each
// accepted run length on a valid/ready port with a saturating event counter.
module fsm_event_monitor #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned LEN_W   = 6,
   parameter int unsigned MIN_LEN = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             det_in,
   input  logic             clr,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [LEN_W-1:0] evt_len,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);

   logic [0:0]       state_q, state_d;
   logic [LEN_W-1:0] run_q, run_d;
   logic             valid_q, valid_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             run_end;
   logic             accept;

   assign run_end = (state_q == RUN) && !det_in;
   assign accept  = run_end && (run_q >= MIN_L);

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      valid_d = valid_q;
      len_d   = len_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (det_in) begin
               state_d = RUN;
               run_d   = LEN_W'(1);
            end
         end
         default: begin
            if (det_in) begin
               run_d = (run_q == LEN_MAX) ? run_q : run_q + LEN_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
      endcase

      if (valid_q && evt_ready) begin
         valid_d = 1'b0;
      end

      // A slot freed by a handshake on this edge can take the new result immediately.
      if (accept) begin
         count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
         if (!valid_q || evt_ready) begin
            valid_d = 1'b1;
            len_d   = run_q;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         run_q   <= '0;
         valid_q <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         valid_q <= valid_d;
         len_q   <= len_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_len   = len_q;
   assign evt_count = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fsm_event_monitor.sv
// Directed bench for fsm_event_monitor: three parameterisations, result lengths
// checked through per-instance scoreboard queues, counters/flags checked inline.
module tb_fsm_event_monitor;

   logic clk;
   logic resetn;
   logic clr;
   logic evt_ready;
   logic det_a, det_b, det_c;

   logic       va, vb, vc;
   logic [5:0] la, lb;
   logic [2:0] lc;
   logic [7:0] ca, cb;
   logic [1:0] cc;
   logic       oa, ob, oc;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int q_a[$];
   int q_b[$];
   int q_c[$];

   logic pv_a = 1'b0;
   logic pv_b = 1'b0;
   logic pv_c = 1'b0;

   fsm_event_monitor u_a (
      .clk(clk), .resetn(resetn), .det_in(det_a), .clr(clr), .evt_ready(evt_ready),
      .evt_valid(va), .evt_len(la), .evt_count(ca), .overflow(oa)
   );

   fsm_event_monitor #(.MIN_LEN(2)) u_b (
      .clk(clk), .resetn(resetn), .det_in(det_b), .clr(clr), .evt_ready(evt_ready),
      .evt_valid(vb), .evt_len(lb), .evt_count(cb), .overflow(ob)
   );

   fsm_event_monitor #(.CNT_W(2), .LEN_W(3)) u_c (
      .clk(clk), .resetn(resetn), .det_in(det_c), .clr(clr), .evt_ready(evt_ready),
      .evt_valid(vc), .evt_len(lc), .evt_count(cc), .overflow(oc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // A new result appears when valid is seen high and the slot was empty or handed off.
   always @(posedge clk) begin
      #1;
      if (va && (!pv_a || evt_ready)) begin
         if (q_a.size() == 0) check("mon_a_unexpected", 32'd1, 32'd0);
         else check("mon_a_len", 32'(la), 32'(q_a.pop_front()));
      end
      if (vb && (!pv_b || evt_ready)) begin
         if (q_b.size() == 0) check("mon_b_unexpected", 32'd1, 32'd0);
         else check("mon_b_len", 32'(lb), 32'(q_b.pop_front()));
      end
      if (vc && (!pv_c || evt_ready)) begin
         if (q_c.size() == 0) check("mon_c_unexpected", 32'd1, 32'd0);
         else check("mon_c_len", 32'(lc), 32'(q_c.pop_front()));
      end
      pv_a = va;
      pv_b = vb;
      pv_c = vc;
   end

   task automatic set_det(input int which, input logic v);
      case (which)
         0: det_a = v;
         1: det_b = v;
         default: det_c = v;
      endcase
   endtask

   // High for len edges, then one low edge; returns at the negedge after the end edge.
   task automatic run(input int which, input int len);
      set_det(which, 1'b1);
      repeat (len) @(negedge clk);
      set_det(which, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      // 1: reset with det high
      resetn = 1'b0; clr = 1'b0; evt_ready = 1'b1;
      det_a = 1'b1; det_b = 1'b1; det_c = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(va), 32'd0);
      check("rst_len", 32'(la), 32'd0);
      check("rst_count", 32'(ca), 32'd0);
      check("rst_ovf", 32'(oa), 32'd0);
      resetn = 1'b1; det_a = 1'b0; det_b = 1'b0; det_c = 1'b0;
      @(negedge clk);
      check("rel_valid", 32'(va), 32'd0);
      @(negedge clk);
      check("rel_count", 32'(ca), 32'd0);

      // 2: run of 3, ready high
      q_a.push_back(3);
      det_a = 1'b1;
      repeat (3) @(negedge clk);
      check("t2_valid_during", 32'(va), 32'd0);
      det_a = 1'b0;
      @(negedge clk);
      check("t2_valid", 32'(va), 32'd1);
      check("t2_len", 32'(la), 32'd3);
      check("t2_count", 32'(ca), 32'd1);
      @(negedge clk);
      check("t2_valid_drop", 32'(va), 32'd0);

      // 3: MIN_LEN=2 filters a 1-cycle pulse
      run(1, 1);
      check("t3_glitch_valid", 32'(vb), 32'd0);
      check("t3_glitch_count", 32'(cb), 32'd0);
      q_b.push_back(2);
      run(1, 2);
      check("t3_valid", 32'(vb), 32'd1);
      check("t3_len", 32'(lb), 32'd2);
      check("t3_count", 32'(cb), 32'd1);
      @(negedge clk);
      check("t3_valid_drop", 32'(vb), 32'd0);

      // 4: backpressure and overflow
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t4_clr_pre", 32'(ca), 32'd0);
      evt_ready = 1'b0;
      q_a.push_back(2);
      run(0, 2);
      check("t4_first_valid", 32'(va), 32'd1);
      check("t4_first_ovf", 32'(oa), 32'd0);
      run(0, 4);
      check("t4_valid", 32'(va), 32'd1);
      check("t4_len_held", 32'(la), 32'd2);
      check("t4_ovf", 32'(oa), 32'd1);
      check("t4_count", 32'(ca), 32'd2);
      evt_ready = 1'b1;
      @(negedge clk);
      check("t4_valid_drop", 32'(va), 32'd0);
      check("t4_len_keep", 32'(la), 32'd2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t4_clr_count", 32'(ca), 32'd0);
      check("t4_clr_ovf", 32'(oa), 32'd0);

      // 5: length and count saturation
      q_c.push_back(7);
      run(2, 10);
      check("t5_len_sat", 32'(lc), 32'd7);
      check("t5_count1", 32'(cc), 32'd1);
      for (int i = 0; i < 4; i++) begin
         q_c.push_back(1);
         run(2, 1);
         if (i == 1) check("t5_count3", 32'(cc), 32'd3);
      end
      check("t5_count_nowrap", 32'(cc), 32'd3);
      check("t5_ovf", 32'(oc), 32'd0);

      // 6: reset mid-run discards it; post-reset run counts from 1
      det_a = 1'b1;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", 32'(va), 32'd0);
      check("t6_rst_count", 32'(ca), 32'd0);
      resetn = 1'b1;
      q_a.push_back(2);
      run(0, 2);
      check("t6_len", 32'(la), 32'd2);
      check("t6_count", 32'(ca), 32'd1);

      // 6b: clr coincident with an event end
      q_a.push_back(3);
      det_a = 1'b1;
      repeat (3) @(negedge clk);
      det_a = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t6_clr_count", 32'(ca), 32'd0);
      check("t6_clr_valid", 32'(va), 32'd1);
      check("t6_clr_len", 32'(la), 32'd3);

      repeat (3) @(negedge clk);
      check("q_a_drained", 32'(q_a.size()), 32'd0);
      check("q_b_drained", 32'(q_b.size()), 32'd0);
      check("q_c_drained", 32'(q_c.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
